// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the operand-forwarding stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fwd_pkg;

  // Default register address width and the hard-wired zero register.
  localparam int REG_AW = 5;
  localparam int REG_X0 = 0;

  // Select code meaning "take the register-file data"; source j uses code j+1.
  localparam int SEL_RF = 0;

  // Width of a forwarding select: the RF plus one code per source.
  function automatic int sel_w(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/fwd_match_pick.sv
// Per-read-port forwarding pick: youngest matching producer wins, else RF data.
// Latency: combinational.
// Backpressure: none; not_rdy flags a winning producer whose data is not yet available.
//
// Ports:
//   rs        source register address of this read port
//   rf_data   register-file read data for this port
//   src_*     in-flight producer valid / destination / data / data-ready (index 0 = youngest)
//   data      selected operand
//   sel       select code: SEL_RF, or j+1 for source j
//   not_rdy   winning source has no data yet (load-use)
module fwd_match_pick
  import fwd_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = fwd_pkg::REG_AW,
  parameter int SEL_W   = fwd_pkg::sel_w(NUM_SRC)
) (
  input  logic [REG_AW-1:0]         rs,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd,
  input  logic [NUM_SRC*XLEN-1:0]   src_data,
  input  logic [NUM_SRC-1:0]        src_rdy,
  output logic [XLEN-1:0]           data,
  output logic [SEL_W-1:0]          sel,
  output logic                      not_rdy
);

  logic [NUM_SRC-1:0] match;
  logic               rs_nonzero;

  // x0 never forwards, even if some producer claims it as a destination.
  assign rs_nonzero = (rs != REG_AW'(REG_X0));

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_match
    assign match[j] = src_valid[j] && (src_rd[j*REG_AW +: REG_AW] == rs) && rs_nonzero;
  end

  // Walk oldest to youngest so the youngest match overwrites. The ready flag
  // follows the winner only: an older ready copy is stale and must not mask
  // a younger pending load.
  always_comb begin
    sel     = SEL_W'(SEL_RF);
    not_rdy = 1'b0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (match[j]) begin
        sel     = SEL_W'(j + 1);
        not_rdy = ~src_rdy[j];
      end
    end
  end

  // Decode every select code; anything that is not a live source code
  // (including unused codes above NUM_SRC) falls back to the RF.
  always_comb begin
    data = rf_data;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (sel == SEL_W'(j + 1)) begin
        data = src_data[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/fwd_operand_stage.sv
// ID->EX operand forwarding with load-use stall and a valid/ready EX operand register.
// Latency: 1 cycle from accepted ID instruction to out_valid_o.
// Backpressure: holds outputs while out_valid_o && !out_ready_i; in_ready_o drops on hazard or full register.
//
// Ports:
//   clk_i, rst_n_i            clock / async active-low reset
//   in_valid_i, in_ready_o    ID handshake
//   rs_addr_i, rf_data_i      per-port source address and RF data (port p at slice p)
//   src_valid_i/rd/data/rdy   in-flight producers, index 0 = youngest
//   flush_i                   kill the registered operand, suppress capture
//   out_valid_o, out_ready_i  EX handshake
//   op_data_o, fwd_sel_o      registered operands and selects
//   hazard_o, hazard_cnt_o    load-use stall and saturating stall-cycle count
module fwd_operand_stage
  import fwd_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_RD  = 2,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = fwd_pkg::REG_AW,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = fwd_pkg::sel_w(NUM_SRC)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [NUM_RD*REG_AW-1:0]  rs_addr_i,
  input  logic [NUM_RD*XLEN-1:0]    rf_data_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_rd_i,
  input  logic [NUM_SRC*XLEN-1:0]   src_data_i,
  input  logic [NUM_SRC-1:0]        src_rdy_i,
  input  logic                      flush_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [NUM_RD*XLEN-1:0]    op_data_o,
  output logic [NUM_RD*SEL_W-1:0]   fwd_sel_o,
  output logic                      hazard_o,
  output logic [CNT_W-1:0]          hazard_cnt_o
);

  logic [NUM_RD*XLEN-1:0]  pick_data;
  logic [NUM_RD*SEL_W-1:0] pick_sel;
  logic [NUM_RD-1:0]       pick_not_rdy;
  logic                    capture;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_match_pick #(
      .XLEN    (XLEN),
      .NUM_SRC (NUM_SRC),
      .REG_AW  (REG_AW),
      .SEL_W   (SEL_W)
    ) u_pick (
      .rs        (rs_addr_i[p*REG_AW +: REG_AW]),
      .rf_data   (rf_data_i[p*XLEN +: XLEN]),
      .src_valid (src_valid_i),
      .src_rd    (src_rd_i),
      .src_data  (src_data_i),
      .src_rdy   (src_rdy_i),
      .data      (pick_data[p*XLEN +: XLEN]),
      .sel       (pick_sel[p*SEL_W +: SEL_W]),
      .not_rdy   (pick_not_rdy[p])
    );
  end

  assign hazard_o = in_valid_i && (|pick_not_rdy);

  // Flush deliberately stays out of in_ready_o to keep it off the flush path;
  // the capture term below is what actually drops the instruction.
  assign in_ready_o = !hazard_o && (!out_valid_o || out_ready_i);
  assign capture    = in_valid_i && in_ready_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (capture) begin
      out_valid_o <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // Data only moves on capture; on drain or flush the old operand is left in
  // place since nobody looks at it once out_valid_o is low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_data_o <= '0;
      fwd_sel_o <= '0;
    end else if (capture) begin
      op_data_o <= pick_data;
      fwd_sel_o <= pick_sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hazard_cnt_o <= '0;
    end else if (hazard_o && (hazard_cnt_o != {CNT_W{1'b1}})) begin
      hazard_cnt_o <= hazard_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Directed scoreboard bench for fwd_operand_stage (2 ports, 2 sources, CNT_W=2).
// Latency: expected operands are pushed at issue, popped by a monitor on each EX transfer.
// Backpressure: stalls, holds and flushes are driven and checked directly.
module tb_fwd_operand_stage;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int CW   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  rs_addr;
  logic [63:0] rf_data;
  logic [1:0]  src_valid;
  logic [9:0]  src_rd;
  logic [63:0] src_data;
  logic [1:0]  src_rdy;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] op_data;
  logic [3:0]  fwd_sel;
  logic        hazard;
  logic [CW-1:0] hazard_cnt;

  typedef struct packed {
    logic [63:0] op;
    logic [3:0]  sel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fwd_operand_stage #(
    .XLEN(XLEN), .NUM_RD(2), .NUM_SRC(2), .REG_AW(AW), .CNT_W(CW)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .rs_addr_i    (rs_addr),
    .rf_data_i    (rf_data),
    .src_valid_i  (src_valid),
    .src_rd_i     (src_rd),
    .src_data_i   (src_data),
    .src_rdy_i    (src_rdy),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .op_data_o    (op_data),
    .fwd_sel_o    (fwd_sel),
    .hazard_o     (hazard),
    .hazard_cnt_o (hazard_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] rf1, input logic [31:0] rf2);
    rs_addr = {rs2, rs1};
    rf_data = {rf2, rf1};
  endtask

  task automatic set_src(input int j, input logic v, input logic [4:0] rd,
                         input logic [31:0] d, input logic r);
    src_valid[j]          = v;
    src_rd[j*AW +: AW]    = rd;
    src_data[j*XLEN +: XLEN] = d;
    src_rdy[j]            = r;
  endtask

  task automatic expect_cap(input logic [31:0] op0, input logic [31:0] op1,
                            input logic [1:0] sel0, input logic [1:0] sel1);
    exp_t e;
    e.op  = {op1, op0};
    e.sel = {sel1, sel0};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every EX transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_op_data", op_data, e.op);
        chk("sb_fwd_sel", 64'(fwd_sel), 64'(e.sel));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rs_addr = '0; rf_data = '0; src_valid = '0; src_rd = '0; src_data = '0; src_rdy = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_op_data", op_data, 64'd0);
    chk("rst_fwd_sel", 64'(fwd_sel), 64'd0);
    chk("rst_hazard_cnt", 64'(hazard_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic: no matches, both ports from RF.
    in_valid = 1'b1;
    set_in(5'd5, 5'd0, 32'h11, 32'h22);
    expect_cap(32'h11, 32'h22, 2'd0, 2'd0);
    tick();
    chk("basic_out_valid", 64'(out_valid), 64'd1);

    // Priority: both sources match rs1, youngest wins.
    set_in(5'd7, 5'd9, 32'h1, 32'h33);
    set_src(0, 1'b1, 5'd7, 32'hA, 1'b1);
    set_src(1, 1'b1, 5'd7, 32'hB, 1'b1);
    expect_cap(32'hA, 32'h33, 2'd1, 2'd0);
    tick();

    // Only the older source remains.
    set_src(0, 1'b0, 5'd7, 32'hA, 1'b1);
    expect_cap(32'hB, 32'h33, 2'd2, 2'd0);
    tick();

    // x0 is never forwarded.
    set_in(5'd1, 5'd0, 32'h44, 32'h0);
    set_src(0, 1'b1, 5'd0, 32'hFF, 1'b1);
    set_src(1, 1'b0, 5'd0, 32'h0, 1'b1);
    expect_cap(32'h44, 32'h0, 2'd0, 2'd0);
    tick();

    // Both ports forward from the older source; younger targets another reg.
    set_in(5'd4, 5'd4, 32'h1, 32'h2);
    set_src(0, 1'b1, 5'd6, 32'h5A, 1'b1);
    set_src(1, 1'b1, 5'd4, 32'h55, 1'b1);
    expect_cap(32'h55, 32'h55, 2'd2, 2'd2);
    tick();

    // Load-use: younger pending load shadows an older ready copy.
    set_in(5'd3, 5'd0, 32'h1, 32'h0);
    set_src(0, 1'b1, 5'd3, 32'h66, 1'b0);
    set_src(1, 1'b1, 5'd3, 32'h77, 1'b1);
    #1;
    chk("lu_hazard", 64'(hazard), 64'd1);
    chk("lu_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("lu_no_capture", 64'(out_valid), 64'd0);
    chk("lu_cnt", 64'(hazard_cnt), 64'd1);
    set_src(0, 1'b1, 5'd3, 32'h66, 1'b1);
    #1;
    chk("lu_hazard_clear", 64'(hazard), 64'd0);
    chk("lu_in_ready_back", 64'(in_ready), 64'd1);
    expect_cap(32'h66, 32'h0, 2'd1, 2'd0);
    tick();
    in_valid = 1'b0;
    src_valid = '0;
    tick();

    // Backpressure: capture, then hold three cycles with a new instruction waiting.
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_in(5'd2, 5'd0, 32'h88, 32'h0);
    tick();
    set_in(5'd2, 5'd0, 32'h99, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_op_data", op_data, {32'h0, 32'h88});
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    flush = 1'b1;
    tick();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    // Flush with room available still suppresses capture.
    tick();
    chk("flush_no_capture", 64'(out_valid), 64'd0);
    flush = 1'b0;
    out_ready = 1'b1;

    // Back-to-back captures at full throughput.
    set_in(5'd8, 5'd9, 32'hA1, 32'hB1);
    expect_cap(32'hA1, 32'hB1, 2'd0, 2'd0);
    tick();
    set_in(5'd8, 5'd9, 32'hA2, 32'hB2);
    expect_cap(32'hA2, 32'hB2, 2'd0, 2'd0);
    tick();
    chk("tput_out_valid", 64'(out_valid), 64'd1);

    // Counter saturation: four more hazard cycles after the first -> 3.
    set_in(5'd3, 5'd0, 32'h1, 32'h0);
    set_src(0, 1'b1, 5'd3, 32'h66, 1'b0);
    tick();
    chk("cnt_two", 64'(hazard_cnt), 64'd2);
    tick();
    tick();
    tick();
    chk("cnt_saturate", 64'(hazard_cnt), 64'd3);
    chk("cnt_hazard_still", 64'(hazard), 64'd1);

    // Reset in the middle of a held transfer.
    src_valid = '0;
    out_ready = 1'b0;
    set_in(5'd10, 5'd11, 32'hC1, 32'hC2);
    tick();
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_op_data", op_data, {32'hC2, 32'hC1});
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_op_data", op_data, 64'd0);
    chk("mid_rst_fwd_sel", 64'(fwd_sel), 64'd0);
    chk("mid_rst_cnt", 64'(hazard_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
